// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the packet arbiter and the async FIFO.
// The slave modport is the arbiter's view; the master modport is the requester/FIFO environment.
interface fifo_wr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    full;
   logic                    wr_en;
   logic [DATA_W-1:0]       wr_data;
   logic                    grant_valid;
   logic [ID_W-1:0]         grant_id;

   modport slave (
      input  req_valid, req_last, req_data, full,
      output req_ready, wr_en, wr_data, grant_valid, grant_id
   );

   modport master (
      output req_valid, req_last, req_data, full,
      input  req_ready, wr_en, wr_data, grant_valid, grant_id
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding the single FIFO write port; a grant is held for a
// whole packet or MAX_BURST beats, whichever ends first, and never writes while full.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 8,
   parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_wr_arbiter_if.slave     bus
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   gid_q, gid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DATA_W-1:0] beat [N_REQ];
   logic [ID_W-1:0]   sel_id;
   logic [ID_W-1:0]   idx_id;
   int                idx;
   logic [N_REQ-1:0]  ready_c;
   logic              wr_en_c;
   logic [DATA_W-1:0] wr_data_c;
   logic              accept;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign beat[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Walk downward so the last hit is the nearest valid index at or after ptr_q.
   always_comb begin : rr_select
      sel_id = ptr_q;
      idx    = 0;
      idx_id = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         idx_id = ID_W'(idx);
         if (bus.req_valid[idx_id]) begin
            sel_id = idx_id;
         end
      end
   end

   always_comb begin : fsm_next
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      cnt_d     = cnt_q;
      ready_c   = '0;
      wr_en_c   = 1'b0;
      wr_data_c = '0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               gid_d   = sel_id;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            ready_c[gid_q] = !bus.full;
            accept         = bus.req_valid[gid_q] && !bus.full;
            if (accept) begin
               wr_en_c   = 1'b1;
               wr_data_c = beat[gid_q];
               cnt_d     = cnt_q + 1'b1;
               if (bus.req_last[gid_q] || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
                  state_d = IDLE;
                  ptr_d   = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.req_ready   = ready_c;
   assign bus.wr_en       = wr_en_c;
   assign bus.wr_data     = wr_data_c;
   assign bus.grant_valid = (state_q == GRANT);
   assign bus.grant_id    = gid_q;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin packet arbiter that shares the single write port of the 16-entry, 8-bit asynchronous FIFO among several requesters in the write clock domain. It grants one requester at a time and holds the grant for a whole packet, up to a beat limit. It forwards accepted beats as `wr_en`/`wr_data` and honours the FIFO's registered `full` flag. It sits directly in front of the FIFO write side and contains no storage beyond grant state.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `DATA_W`, 8, beat width; must match the FIFO data width.
- `MAX_BURST`, 8, maximum beats per grant (1..16). Must not exceed FIFO depth.
- `ID_W`, ceil(log2(N_REQ)), width of the grant index.

- `clk`  in  1  write-domain clock. All logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_last`  in  N_REQ  per-requester end-of-packet marker. Qualified by the matching `req_valid`.
- `req_data`  in  N_REQ*DATA_W  per-requester beat data. Requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  per-requester accept. At most one bit is high.
- `full`  in  1  FIFO full flag (registered, write domain).
- `wr_en`  out  1  FIFO write strobe.
- `wr_data`  out  DATA_W  FIFO write data.
- `grant_valid`  out  1  a grant is currently held.
- `grant_id`  out  ID_W  index of the granted requester. Meaningful only while `grant_valid` is high.

## Operation
- FSM with two states: IDLE and GRANT. Registers:
  - `state`
  - round-robin pointer `ptr` (ID_W bits)
  - `grant_id`
  - beat counter `cnt` (ceil(log2(MAX_BURST+1)) bits)
- IDLE:
  - No `req_ready`, `wr_en` = 0.
  - If any `req_valid` bit is set, select the first set bit at or after `ptr`, searching upward and wrapping modulo N_REQ.
  - Register the selection into `grant_id`, clear `cnt`, and go to GRANT.
- GRANT, with g = `grant_id`:
  - `req_ready[g]` = !full. All other ready bits are 0.
  - Accept = `req_valid[g]` & `req_ready[g]`.
  - On accept: `wr_en` = 1, `wr_data` = beat g, and `cnt` increments.
  - Release when an accepted beat has `req_last[g]` = 1, or when `cnt` == MAX_BURST-1 at accept time.
  - On release: go to IDLE next cycle and set `ptr` <= (g+1) mod N_REQ.
  - If `req_valid[g]` drops mid-packet, the grant is held; there is no timeout.
- `wr_en`, `wr_data` and `req_ready` are combinational from registered state plus `full`/`req_valid`. `wr_data` is 0 when `wr_en` = 0.
- Guarantee: `wr_en` is never high while `full` is high. The FIFO's internal gating is never relied on.
- Fairness: a continuously requesting agent waits at most (N_REQ-1) grants.

## Timing
- Reset values:
  - `state` = IDLE, `ptr` = 0, `grant_id` = 0, `cnt` = 0.
  - `grant_valid` = 0.
  - All `req_ready` = 0, `wr_en` = 0, `wr_data` = 0.
- Arbitration latency: `req_valid` seen in IDLE at edge k gives `grant_valid` = 1 after edge k+1. The first beat can be written in that cycle.
- Throughput: 1 beat/cycle while granted and !full. There is one IDLE bubble cycle between consecutive grants.
- `full` rising: ready and `wr_en` drop in the same cycle. The grant and `cnt` hold; the transfer resumes the cycle `full` falls.
- `req_last` on a non-accepted cycle (valid low or full high) is ignored.
- MAX_BURST = 1: every grant carries exactly one beat.
- Reset asserted mid-packet:
  - Immediate return to reset values and no further writes.
  - The partial packet already in the FIFO is not recalled.
- Requesters must hold `req_data`/`req_last` stable while `req_valid` is high and not accepted.

## Test plan
- Single requester, 3-beat packet: `req_valid[0]`=1, data 0x11/0x22/0x33, last on 0x33. Required:
  - grant to 0 one cycle after valid.
  - `wr_en` high for 3 consecutive cycles with data 0x11, 0x22, 0x33.
  - IDLE next cycle; `ptr`=1.
- All 4 requesters valid, 1-beat packets: required grant order 0,1,2,3,0. Each grant is separated by one IDLE cycle.
- Burst cap: MAX_BURST=8, requester 2 streams 12 beats without last. Required:
  - release after 8 writes.
  - with requester 3 also valid, grant 3 next; otherwise requester 2 is re-granted and writes its remaining 4 beats.
- Full backpressure: `full` forced high for 5 cycles mid-packet after beat 2 of 4. Required:
  - `wr_en`=0 and `req_ready`=0 for those 5 cycles.
  - `grant_id` unchanged.
  - beats 3 and 4 written after `full` falls, with no loss or duplication.
- Valid gap: requester 1 drops valid for 3 cycles mid-packet while requester 0 is valid. Required: grant stays on 1 with no write to the FIFO on behalf of requester 0 until 1's last beat.
- Reset mid-grant: `rst` low during beat 2. Required:
  - `wr_en`, `grant_valid` and `req_ready` go to 0 asynchronously.
  - after release, the first grant goes to the lowest valid index starting from `ptr`=0.
